// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: core-wide datapath types
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/my_types_pkg.sv
// my_types_pkg: fetch-stage state and IF/ID latch types
package my_types_pkg;
    import cpu_types_pkg::*;
    typedef enum logic {RUN, HALTED} fetch_state_t;
    typedef struct packed {
        logic        valid;
        word_t       instr;
        logic [15:0] imm16;
        word_t       npc;
    } ifid_t;
    localparam word_t NOP_INSTR = '0;
    localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, instr: NOP_INSTR, imm16: 16'h0, npc: 32'h0};
endpackage

// File: rtl/fetch_stage_ifid_latch.sv
// ifid_latch: IF/ID pipeline register with hold and bubble-insert controls
module ifid_latch
    import my_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  hold,
    input  logic  bubble,
    input  ifid_t d,
    output ifid_t q
);
    always_ff @(posedge CLK or posedge RST)
        if (RST) q <= IFID_BUBBLE;
        else if (!hold) q <= bubble ? IFID_BUBBLE : d;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, icache request, redirect/stall/flush/halt handling and IF/ID latch
module fetch_stage
    import cpu_types_pkg::*;
    import my_types_pkg::*;
#(
    parameter word_t PC0   = 32'h0000_0000,
    parameter int    CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic [31:0]      imemload,
    output logic             imemREN,
    output logic [31:0]      imemaddr,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect_en,
    input  logic [31:0]      redirect_pc,
    input  logic             halt,
    output logic             ifid_valid,
    output logic [31:0]      ifid_instr,
    output logic [15:0]      ifid_imm16,
    output logic [31:0]      ifid_npc,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);
    fetch_state_t state, state_n;
    word_t pc, pc_n, pc_inc;
    logic run, load, hold_ifid;
    ifid_t ifid_d, ifid_q;
    assign run       = state == RUN;
    assign pc_inc    = pc + 32'd4;
    assign load      = run && !redirect_en && !halt && !stall && !flush && ihit;
    assign hold_ifid = !run || (!redirect_en && !halt && stall);
    assign ifid_d    = '{valid: 1'b1, instr: imemload, imm16: imemload[15:0], npc: pc_inc};
    always_comb begin
        state_n = (run && !redirect_en && halt) ? HALTED : state;
        pc_n    = (run && redirect_en) ? (redirect_pc & ~32'h3) : load ? pc_inc : pc;
    end
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state       <= RUN;
            pc          <= PC0;
            fetch_count <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            if (load) fetch_count <= fetch_count + CNT_W'(1);
        end
    ifid_latch u_ifid (
        .CLK   (CLK),
        .RST   (RST),
        .hold  (hold_ifid),
        .bubble(!load),
        .d     (ifid_d),
        .q     (ifid_q)
    );
    assign imemREN    = run;
    assign imemaddr   = pc;
    assign halted     = state == HALTED;
    assign ifid_valid = ifid_q.valid;
    assign ifid_instr = ifid_q.instr;
    assign ifid_imm16 = ifid_q.imm16;
    assign ifid_npc   = ifid_q.npc;
endmodule
